// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc: request side (operands, opcode,
// in_valid/in_ready) and result side (out, flags, out_valid/out_ready).
interface alu_mc_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [2:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             neg;
    logic             pos;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in0, in1, sel, in_valid, out_ready,
        input  in_ready, out, neg, pos, zero, carry, overflow, out_valid
    );

    modport slave (
        input  in0, in1, sel, in_valid, out_ready,
        output in_ready, out, neg, pos, zero, carry, overflow, out_valid
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic/shift ops, iterative shift-add
// MUL (one multiplier bit per cycle), result held until the consumer takes it.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input logic    clk,
    input logic    rst,
    alu_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
    logic [CW-1:0]    cnt;
    logic             accept, is_mul, mul_last;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] out_q;
    logic             neg_q, pos_q, zero_q, carry_q, ovf_q;

    function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] r);
        return {(r != '0) && r[WIDTH-1], (r != '0) && !r[WIDTH-1], r == '0};
    endfunction

    assign accept   = bus.in_valid && bus.in_ready;
    assign is_mul   = bus.sel == 3'b111;
    assign mul_last = cnt == CW'(WIDTH - 1);
    assign acc_nxt  = mplier[0] ? acc + mcand : acc;
    assign sum      = {1'b0, bus.in0} + {1'b0, bus.in1};
    assign diff     = {1'b0, bus.in0} - {1'b0, bus.in1};

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = state == DONE;
    assign bus.out       = out_q;
    assign bus.neg       = neg_q;
    assign bus.pos       = pos_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;

    // Single-cycle result path; MUL is handled by the EXEC iteration instead.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (bus.sel)
            3'b000: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (bus.in0[WIDTH-1] == bus.in1[WIDTH-1]) &&
                        (sum[WIDTH-1] != bus.in0[WIDTH-1]);
            end
            3'b001: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (bus.in0[WIDTH-1] != bus.in1[WIDTH-1]) &&
                        (diff[WIDTH-1] != bus.in0[WIDTH-1]);
            end
            3'b010: res = bus.in0 & bus.in1;
            3'b011: res = bus.in0 | bus.in1;
            3'b100: res = bus.in0 ^ bus.in1;
            3'b101: res = (32'(bus.in1) >= 32'(WIDTH)) ? '0 : bus.in0 << bus.in1;
            3'b110: res = (32'(bus.in1) >= 32'(WIDTH)) ? '0 : bus.in0 >> bus.in1;
            default: res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_mul ? EXEC : DONE;
            EXEC: if (mul_last) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            out_q   <= '0;
            neg_q   <= 1'b0;
            pos_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                if (is_mul) begin
                    mcand  <= bus.in0;
                    mplier <= bus.in1;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    out_q                   <= res;
                    {neg_q, pos_q, zero_q}  <= flags_of(res);
                    carry_q                 <= res_c;
                    ovf_q                   <= res_v;
                end
            end
            // Product bits above WIDTH are never needed, so mcand just drops its MSBs.
            if (state == EXEC) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                acc    <= acc_nxt;
                cnt    <= cnt + CW'(1);
                if (mul_last) begin
                    out_q                  <= acc_nxt;
                    {neg_q, pos_q, zero_q} <= flags_of(acc_nxt);
                    carry_q                <= 1'b0;
                    ovf_q                  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=8): reset, every opcode, MUL latency,
// result hold under backpressure, back-to-back ops and reset abort of MUL.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_mc_if #(.WIDTH(8)) bus ();
    alu_mc #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [12:0] exp;   // {out, neg, pos, zero, carry, overflow}
    } vec_t;

    function automatic logic [13:0] obs();
        return {bus.out_valid, bus.out, bus.neg, bus.pos, bus.zero, bus.carry, bus.overflow};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        bus.sel = s; bus.in0 = a; bus.in1 = b; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in0 = 8'($urandom); bus.in1 = 8'($urandom); bus.sel = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        checks++;
        if (obs() !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", obs(), 14'h0);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_ops();
        vec_t tbl [0:18] = '{
            '{3'd0, 8'h7F, 8'h01, {8'h80, 5'b10001}},
            '{3'd0, 8'hFF, 8'h01, {8'h00, 5'b00110}},
            '{3'd0, 8'h50, 8'h20, {8'h70, 5'b01000}},
            '{3'd1, 8'h05, 8'h05, {8'h00, 5'b00100}},
            '{3'd1, 8'h03, 8'h05, {8'hFE, 5'b10010}},
            '{3'd1, 8'h80, 8'h01, {8'h7F, 5'b01001}},
            '{3'd2, 8'hF0, 8'h3C, {8'h30, 5'b01000}},
            '{3'd3, 8'h0F, 8'h80, {8'h8F, 5'b10000}},
            '{3'd4, 8'hAA, 8'hAA, {8'h00, 5'b00100}},
            '{3'd6, 8'h80, 8'h09, {8'h00, 5'b00100}},
            '{3'd5, 8'h01, 8'h07, {8'h80, 5'b10000}},
            '{3'd5, 8'h01, 8'h08, {8'h00, 5'b00100}},
            '{3'd6, 8'h80, 8'h07, {8'h01, 5'b01000}},
            '{3'd5, 8'h01, 8'hFF, {8'h00, 5'b00100}},
            '{3'd7, 8'd13, 8'd11, {8'h8F, 5'b10000}},
            '{3'd7, 8'hFF, 8'hFF, {8'h01, 5'b01000}},
            '{3'd7, 8'h00, 8'h37, {8'h00, 5'b00100}},
            '{3'd7, 8'h10, 8'h10, {8'h00, 5'b00100}},
            '{3'd7, 8'h03, 8'h05, {8'h0F, 5'b01000}}
        };
        int lat;
        for (int i = 0; i < 19; i++) begin
            issue(tbl[i].sel, tbl[i].a, tbl[i].b);
            wait_valid(lat);
            checks++;
            if (obs() !== {1'b1, tbl[i].exp}) begin
                failures++;
                $display("FAIL op%0d_sel%0d_result: got %h want %h", i, tbl[i].sel, obs(), {1'b1, tbl[i].exp});
            end
            checks++;
            if (lat != ((tbl[i].sel == 3'd7) ? 9 : 1)) begin
                failures++;
                $display("FAIL op%0d_latency: got %0d want %0d", i, lat, (tbl[i].sel == 3'd7) ? 9 : 1);
            end
            retire();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL op%0d_retire: got valid=%b ready=%b want valid=0 ready=1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_mul_busy();
        int lat;
        issue(3'd7, 8'd13, 8'd11);
        bus.in_valid = 1'b1; bus.sel = 3'd0;
        lat = 1;
        while (!bus.out_valid && lat < 30) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL mul_busy_in_ready cycle %0d: got %b want 0", lat, bus.in_ready);
            end
            step();
            lat++;
        end
        checks++;
        if (lat != 9) begin
            failures++;
            $display("FAIL mul_busy_latency: got %0d want 9", lat);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || obs() !== {1'b1, 8'h8F, 5'b10000}) begin
            failures++;
            $display("FAIL mul_busy_result: got %h ready=%b want %h ready=0", obs(), bus.in_ready, {1'b1, 8'h8F, 5'b10000});
        end
        bus.in_valid = 1'b0;
        retire();
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_busy_no_extra_accept: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_hold();
        issue(3'd2, 8'hFF, 8'h55);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs() !== {1'b1, 8'h55, 5'b01000} || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: got %h ready=%b want %h ready=0", i, obs(), bus.in_ready, {1'b1, 8'h55, 5'b01000});
            end
            step();
        end
        retire();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        issue(3'd0, 8'h01, 8'h02);
        checks++;
        if (obs() !== {1'b1, 8'h03, 5'b01000}) begin
            failures++;
            $display("FAIL b2b_first: got %h want %h", obs(), {1'b1, 8'h03, 5'b01000});
        end
        retire();
        issue(3'd4, 8'h0F, 8'hF0);
        checks++;
        if (obs() !== {1'b1, 8'hFF, 5'b10000}) begin
            failures++;
            $display("FAIL b2b_second: got %h want %h", obs(), {1'b1, 8'hFF, 5'b10000});
        end
        retire();
    endtask

    task automatic test_abort();
        issue(3'd7, 8'd13, 8'd11);
        step(); step();
        rst = 1'b1;
        step();
        checks++;
        if (obs() !== 14'h0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset_outputs: got %h ready=%b want 0 ready=0", obs(), bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_ready: got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out !== 8'h00) begin
                failures++;
                $display("FAIL abort_stale_cycle%0d: got valid=%b out=%h want 0/00", i, bus.out_valid, bus.out);
            end
        end
    endtask

    initial begin
        bus.in0 = '0; bus.in1 = '0; bus.sel = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_ops();
        test_mul_busy();
        test_hold();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
